// File: rtl/parity_stream_gen_pkg.sv
// Shared parity constants and the word-parity helper for the parity stream path.
package parity_pkg;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    // Widest payload par_bit accepts; narrower words are zero-extended, which leaves parity unchanged.
    localparam int   PAR_MAX_W = 64;

    // Parity bit that makes {data, p} even (mode=PAR_EVEN) or odd (mode=PAR_ODD).
    function automatic logic par_bit(input logic [PAR_MAX_W-1:0] data, input logic mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/parity_stream_gen_if.sv
// Stream bundle for the parity generator: upstream word channel plus downstream coded channel.
interface parity_stream_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  odd_sel;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH:0]   m_data;
    logic                  m_last;
    logic                  m_frame_par;

    // Block side: consumes the s channel, produces the m channel.
    modport slave (
        input  s_valid, s_data, s_last, odd_sel, m_ready,
        output s_ready, m_valid, m_data, m_last, m_frame_par
    );

    // Environment side: source on s, sink on m.
    modport master (
        output s_valid, s_data, s_last, odd_sel, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_frame_par
    );
endinterface

// File: rtl/parity_stream_gen_skid_fifo.sv
// Two-entry synchronous FIFO; head is read straight from storage registers.
module parity_skid_fifo #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Full and empty are guarded here too, so a stray request can never corrupt the count.
    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign valid   = (count != 2'd0);
    // Empty FIFO presents zeros so m_data/m_last/m_frame_par are quiet when nothing is held.
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Storage, pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/parity_stream_gen.sv
// Streaming parity generator: appends a per-word parity LSB, tracks frame parity, and buffers
// through a 2-entry queue so s_ready never depends combinationally on m_ready.
module parity_stream_gen
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_stream_gen_if.slave   bus,
    output logic [CNT_WIDTH-1:0] frame_cnt
);
    localparam int FW = DATA_WIDTH + 3;

    logic          rdy_en;
    logic          in_frame;
    logic          mode;
    logic          acc;
    logic [1:0]    count;
    logic          fvalid;
    logic [FW-1:0] din;
    logic [FW-1:0] dout;
    logic          push;
    logic          pop;
    logic          mode_eff;
    logic          data_par;
    logic          word_par;
    logic          frame_bit;

    // First beat of a frame uses the live odd_sel; later beats use the latched mode.
    assign mode_eff  = in_frame ? mode : bus.odd_sel;
    assign data_par  = ^bus.s_data;
    assign word_par  = par_bit(PAR_MAX_W'(bus.s_data), mode_eff);
    assign frame_bit = bus.s_last ? (acc ^ data_par ^ mode_eff) : 1'b0;
    assign din       = {bus.s_data, word_par, bus.s_last, frame_bit};

    assign bus.s_ready = rdy_en && (count != 2'd2);
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = fvalid && bus.m_ready;

    assign bus.m_valid = fvalid;
    assign {bus.m_data, bus.m_last, bus.m_frame_par} = dout;

    parity_skid_fifo #(.WIDTH(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .valid (fvalid),
        .count (count)
    );

    // Frame tracking: mode latch, running data parity, and the post-reset ready enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            in_frame <= 1'b0;
            mode     <= PAR_EVEN;
            acc      <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                if (!in_frame) mode <= bus.odd_sel;
                if (bus.s_last) begin
                    in_frame <= 1'b0;
                    acc      <= 1'b0;
                end else begin
                    in_frame <= 1'b1;
                    acc      <= acc ^ data_par;
                end
            end
        end
    end

    // Count frames once their last beat has actually left the block.
    always_ff @(posedge clk) begin
        if (!rst_n) frame_cnt <= '0;
        else if (pop && bus.m_last) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
endmodule
